// File: rtl/uart_pkg.sv
// Shared definitions for the UART-side blocks: ASCII control characters and
// the command parser state encoding.
package uart_pkg;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_SP = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARG     = 2'd1,
    ST_DISCARD = 2'd2
  } parser_state_e;

endpackage

// File: rtl/ascii_hex_nibble.sv
// Combinational ASCII classifier: hex digit decode and letter upper-casing.
// Shared between the RX command parser and the TX hex formatter.
module ascii_hex_nibble #(
  parameter bit LOWER_OK = 1'b1
) (
  input  logic [7:0] data_i,
  output logic       is_hex,
  output logic [3:0] nibble,
  output logic       is_letter,
  output logic [7:0] upper
);

  // Hex digit decode; letters A-F/a-f share the low nibble offset of 9
  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    if (data_i >= 8'h30 && data_i <= 8'h39) begin
      is_hex = 1'b1;
      nibble = data_i[3:0];
    end else if (data_i >= 8'h41 && data_i <= 8'h46) begin
      is_hex = 1'b1;
      nibble = data_i[3:0] + 4'd9;
    end else if (LOWER_OK && data_i >= 8'h61 && data_i <= 8'h66) begin
      is_hex = 1'b1;
      nibble = data_i[3:0] + 4'd9;
    end else begin
      is_hex = 1'b0;
      nibble = 4'h0;
    end
  end

  // Letter detection with lowercase folded to uppercase when allowed
  always_comb begin
    is_letter = 1'b0;
    upper     = data_i;
    if (data_i >= 8'h41 && data_i <= 8'h5A) begin
      is_letter = 1'b1;
      upper     = data_i;
    end else if (LOWER_OK && data_i >= 8'h61 && data_i <= 8'h7A) begin
      is_letter = 1'b1;
      upper     = data_i - 8'h20;
    end else begin
      is_letter = 1'b0;
      upper     = data_i;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles "<letter><hex digits><CR|LF>" lines from received bytes into a
// one-cycle command strobe; malformed lines give one error strobe.
module uart_cmd_parser
  import uart_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 4,
  parameter bit          LOWER_OK   = 1'b1,
  localparam int unsigned ARG_W     = 4 * MAX_DIGITS,
  localparam int unsigned CNT_W     = $clog2(MAX_DIGITS + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RX_VALID,
  input  logic [7:0]       RX_DATA,
  output logic             CMD_VALID,
  output logic [7:0]       CMD,
  output logic [ARG_W-1:0] ARG,
  output logic [CNT_W-1:0] ARG_DIGITS,
  output logic             ERR
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

  parser_state_e    state_q, state_d;
  logic [7:0]       letter_q, letter_d;
  logic [ARG_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             err_q, err_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [ARG_W-1:0] arg_q, arg_d;
  logic [CNT_W-1:0] arg_digits_q, arg_digits_d;

  logic       is_hex, is_letter, is_term, is_blank;
  logic [3:0] nibble;
  logic [7:0] upper;

  ascii_hex_nibble #(.LOWER_OK(LOWER_OK)) u_classify (
    .data_i    (RX_DATA),
    .is_hex    (is_hex),
    .nibble    (nibble),
    .is_letter (is_letter),
    .upper     (upper)
  );

  assign is_term  = (RX_DATA == CHAR_CR) || (RX_DATA == CHAR_LF);
  assign is_blank = (RX_DATA == CHAR_SP);

  // Next-state and output logic; nothing moves unless a byte is offered
  always_comb begin
    state_d      = state_q;
    letter_d     = letter_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    cmd_valid_d  = 1'b0;
    err_d        = 1'b0;
    cmd_d        = cmd_q;
    arg_d        = arg_q;
    arg_digits_d = arg_digits_q;
    if (RX_VALID) begin
      case (state_q)
        ST_IDLE: begin
          if (is_term || is_blank) begin
            state_d = ST_IDLE;
          end else if (is_letter) begin
            letter_d = upper;
            acc_d    = {ARG_W{1'b0}};
            cnt_d    = {CNT_W{1'b0}};
            state_d  = ST_ARG;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DISCARD;
          end
        end
        ST_ARG: begin
          // Hex is tested before anything else: A-F are letters too
          if (is_hex) begin
            if (cnt_q < MAX_CNT) begin
              acc_d = (acc_q << 4) | ARG_W'(nibble);
              cnt_d = cnt_q + CNT_W'(1);
            end else begin
              err_d   = 1'b1;
              state_d = ST_DISCARD;
            end
          end else if (is_blank) begin
            state_d = ST_ARG;
          end else if (is_term) begin
            cmd_valid_d  = 1'b1;
            cmd_d        = letter_q;
            arg_d        = acc_q;
            arg_digits_d = cnt_q;
            state_d      = ST_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (is_term) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DISCARD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers; reset drops any byte offered in the same cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      letter_q     <= 8'h00;
      acc_q        <= {ARG_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      cmd_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      cmd_q        <= 8'h00;
      arg_q        <= {ARG_W{1'b0}};
      arg_digits_q <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      letter_q     <= letter_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      cmd_valid_q  <= cmd_valid_d;
      err_q        <= err_d;
      cmd_q        <= cmd_d;
      arg_q        <= arg_d;
      arg_digits_q <= arg_digits_d;
    end
  end

  assign CMD_VALID  = cmd_valid_q;
  assign ERR        = err_q;
  assign CMD        = cmd_q;
  assign ARG        = arg_q;
  assign ARG_DIGITS = arg_digits_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: each byte's strobes are checked one
// cycle later, and the latched command fields are checked after each line.
module tb_uart_cmd_parser;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        RX_VALID = 1'b0;
  logic [7:0]  RX_DATA = 8'h00;
  logic        CMD_VALID;
  logic [7:0]  CMD;
  logic [15:0] ARG;
  logic [2:0]  ARG_DIGITS;
  logic        ERR;

  int n_checks = 0;
  int n_fail   = 0;

  uart_cmd_parser #(.MAX_DIGITS(4), .LOWER_OK(1'b1)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_VALID   (RX_VALID),
    .RX_DATA    (RX_DATA),
    .CMD_VALID  (CMD_VALID),
    .CMD        (CMD),
    .ARG        (ARG),
    .ARG_DIGITS (ARG_DIGITS),
    .ERR        (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one byte (RX_VALID left high so calls chain back-to-back), then
  // check the strobes it produced one cycle later.
  task automatic put(input logic [7:0] b, input logic ev, input logic ee);
    RX_VALID = 1'b1;
    RX_DATA  = b;
    @(posedge CLK); #1;
    chk($sformatf("cmd_valid after %02h", b), 32'(CMD_VALID), 32'(ev));
    chk($sformatf("err after %02h", b), 32'(ERR), 32'(ee));
  endtask

  task automatic put_quiet(input string s);
    for (int i = 0; i < s.len(); i++) put(s[i], 1'b0, 1'b0);
  endtask

  task automatic gap(input int n);
    RX_VALID = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      chk("idle cmd_valid", 32'(CMD_VALID), 32'd0);
      chk("idle err", 32'(ERR), 32'd0);
    end
  endtask

  task automatic outs(input string tag, input logic [7:0] c, input logic [15:0] a, input logic [2:0] d);
    chk({tag, " cmd"}, 32'(CMD), 32'(c));
    chk({tag, " arg"}, 32'(ARG), 32'(a));
    chk({tag, " digits"}, 32'(ARG_DIGITS), 32'(d));
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("reset cmd_valid", 32'(CMD_VALID), 32'd0);
    chk("reset err", 32'(ERR), 32'd0);
    outs("reset", 8'h00, 16'h0000, 3'd0);
    RST = 1'b0;

    // Slow stream, one byte every third cycle
    put(8'h53, 1'b0, 1'b0); gap(2);
    put(8'h31, 1'b0, 1'b0); gap(2);
    put(8'h41, 1'b0, 1'b0); gap(2);
    put(8'h32, 1'b0, 1'b0); gap(2);
    put(8'h46, 1'b0, 1'b0); gap(2);
    put(8'h0D, 1'b1, 1'b0);
    outs("S1A2F", 8'h53, 16'h1A2F, 3'd4);
    gap(2);

    // Back-to-back lowercase line with embedded blank and CR+LF
    put_quiet("w ff");
    put(8'h0D, 1'b1, 1'b0);
    outs("w ff", 8'h57, 16'h00FF, 3'd2);
    put(8'h0A, 1'b0, 1'b0);
    gap(1);

    // Zero-digit command then empty lines
    put(8'h52, 1'b0, 1'b0);
    put(8'h0A, 1'b1, 1'b0);
    outs("R", 8'h52, 16'h0000, 3'd0);
    put(8'h0D, 1'b0, 1'b0);
    put(8'h0A, 1'b0, 1'b0);
    put(8'h0A, 1'b0, 1'b0);
    gap(1);

    // Fifth digit overflows; outputs hold
    put_quiet("P1234");
    put(8'h35, 1'b0, 1'b1);
    put(8'h0D, 1'b0, 1'b0);
    outs("after overflow", 8'h52, 16'h0000, 3'd0);
    put_quiet("Q7");
    put(8'h0D, 1'b1, 1'b0);
    outs("Q7", 8'h51, 16'h0007, 3'd1);

    // Leading zeros count as digits
    put_quiet("X0001");
    put(8'h0D, 1'b1, 1'b0);
    outs("X0001", 8'h58, 16'h0001, 3'd4);

    // Bad first byte, then bad byte mid-argument: one ERR each
    put(8'h33, 1'b0, 1'b1);
    put(8'h47, 1'b0, 1'b0);
    put(8'h0D, 1'b0, 1'b0);
    put_quiet("T1");
    put(8'h5A, 1'b0, 1'b1);
    put(8'h39, 1'b0, 1'b0);
    put(8'h0D, 1'b0, 1'b0);
    outs("after errors", 8'h58, 16'h0001, 3'd4);
    gap(1);

    // Reset mid-line loses the partial command
    put_quiet("S12");
    RX_VALID = 1'b0;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    outs("mid-line reset", 8'h00, 16'h0000, 3'd0);
    put(8'h0D, 1'b0, 1'b0);
    put(8'h41, 1'b0, 1'b0);
    put(8'h35, 1'b0, 1'b0);
    put(8'h0D, 1'b1, 1'b0);
    outs("A5", 8'h41, 16'h0005, 3'd1);
    gap(1);

    // Reset coincident with a terminator drops that byte
    put_quiet("B3");
    RST      = 1'b1;
    RX_VALID = 1'b1;
    RX_DATA  = 8'h0D;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("reset+CR cmd_valid", 32'(CMD_VALID), 32'd0);
    outs("reset+CR", 8'h00, 16'h0000, 3'd0);
    put(8'h0D, 1'b0, 1'b0);
    gap(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
